// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result buffer slice: opcode
// encoding, the per-result {Z,N,V} flag record and the ALU datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_NAND = 2'b10,
    ALU_XOR  = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

  // ADD and SUB are the only opcodes that produce meaningful sign/overflow.
  function automatic logic is_arith(input logic [1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU (producer), the result buffer and the
// writeback consumer. The buffer takes the slave view; whoever drives the
// ALU side and consumes results takes the master view.
interface alu_result_buffer_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_error;
  logic [1:0]       in_opcode;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_flags;

  modport master (
    output in_valid, in_result, in_error, in_opcode, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_result, in_error, in_opcode, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

endinterface

// File: rtl/result_fifo.sv
// Generic synchronous FIFO storage: DEPTH entries of WIDTH bits, wrapping
// pointers and an occupancy counter from which full/empty are derived.
// Head data is read straight from storage, so there is no in->out bypass.
module result_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; cleared on reset so the head reads zero until first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer advance, wrapping naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy tracking; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// ALU result buffer: captures ALU results with a valid/ready handshake,
// tags each with {Z,N,V} flags, queues them in result_fifo and commits the
// architectural flag register when an entry is drained.
// Optional feature: define ALU_RESULT_BUFFER_ERRCNT_EN to add err_count,
// a saturating count of arithmetic pushes that reported overflow.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_result_buffer_if.slave      bus,
  output alu_flags_t              flag_reg,
  output logic [$clog2(DEPTH):0]  count
`ifdef ALU_RESULT_BUFFER_ERRCNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam int EW = WIDTH + 3;

  alu_flags_t     in_flags;
  alu_flags_t     head_flags;
  logic [EW-1:0]  wr_entry;
  logic [EW-1:0]  rd_entry;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  assign push = bus.in_valid && !full;
  assign pop  = bus.out_ready && !empty;

  // Flags for the incoming result; logic ops carry forward committed N/V.
  always_comb begin
    in_flags   = '0;
    in_flags.z = (bus.in_result == '0);
    if (is_arith(bus.in_opcode)) begin
      in_flags.n = bus.in_result[WIDTH-1];
      in_flags.v = bus.in_error;
    end else begin
      in_flags.n = flag_reg.n;
      in_flags.v = flag_reg.v;
    end
  end

  assign wr_entry = {bus.in_result, in_flags};

  result_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign head_flags     = rd_entry[2:0];
  assign bus.in_ready   = !full;
  assign bus.out_valid  = !empty;
  assign bus.out_result = rd_entry[EW-1:3];
  assign bus.out_flags  = head_flags;

  // Architectural flags follow the entry handed to the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_reg <= '0;
    end else if (pop) begin
      flag_reg <= head_flags;
    end
  end

`ifdef ALU_RESULT_BUFFER_ERRCNT_EN
  // Saturating tally of accepted ADD/SUB results flagged as overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (push && bus.in_error && is_arith(bus.in_opcode) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: a table of single push/pop
// vectors with hand-derived flags, plus sequences for reset, flag
// inheritance, full-blocking and streaming, all tracked by a scoreboard.
module tb_alu_result_buffer;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] flag_reg;
  logic [2:0] count;
`ifdef ALU_RESULT_BUFFER_ERRCNT_EN
  logic [7:0] err_count;
  int         model_err;
`endif

  alu_result_buffer_if #(.WIDTH(4)) bus ();

  alu_result_buffer #(
    .WIDTH (4),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .flag_reg (flag_reg),
    .count    (count)
`ifdef ALU_RESULT_BUFFER_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  typedef struct {
    logic [1:0] op;
    logic [3:0] res;
    logic       err;
    logic [2:0] exp_flags;
  } vec_t;

  vec_t       vecs [10];
  logic [6:0] sb [$];
  logic [2:0] model_flag_reg;
  int         checks;
  int         errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_flags(input logic [1:0] op, input logic [3:0] res,
                                             input logic err, input logic [2:0] cur);
    logic [2:0] f;
    f[2] = (res == 4'h0);
    if (op == 2'b00 || op == 2'b01) begin
      f[1] = res[3];
      f[0] = err;
    end else begin
      f[1] = cur[1];
      f[0] = cur[0];
    end
    return f;
  endfunction

  task automatic checkOutput();
    check("count", 32'(count), 32'(sb.size()));
    check("in_ready", 32'(bus.in_ready), 32'(sb.size() < DEPTH));
    check("out_valid", 32'(bus.out_valid), 32'(sb.size() > 0));
    check("flag_reg", 32'(flag_reg), 32'(model_flag_reg));
    if (sb.size() > 0) begin
      check("head_result", 32'(bus.out_result), 32'(sb[0][6:3]));
      check("head_flags", 32'(bus.out_flags), 32'(sb[0][2:0]));
    end
`ifdef ALU_RESULT_BUFFER_ERRCNT_EN
    check("err_count", 32'(err_count), 32'(model_err));
`endif
  endtask

  // One clock of stimulus: predict push/pop, compare popped entry, update model.
  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [3:0] res,
                               input logic err, input logic rdy);
    logic       exp_push;
    logic       exp_pop;
    logic [2:0] nf;
    logic [6:0] popped;
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_result = res;
    bus.in_error  = err;
    bus.out_ready = rdy;
    popped        = '0;
    #1;
    exp_push = v && (sb.size() < DEPTH);
    exp_pop  = rdy && (sb.size() > 0);
    nf       = model_flags(op, res, err, model_flag_reg);
    if (exp_pop) begin
      popped = sb.pop_front();
      check("pop_result", 32'(bus.out_result), 32'(popped[6:3]));
      check("pop_flags", 32'(bus.out_flags), 32'(popped[2:0]));
    end
    @(posedge clk);
    if (exp_pop) model_flag_reg = popped[2:0];
    if (exp_push) begin
      sb.push_back({res, nf});
`ifdef ALU_RESULT_BUFFER_ERRCNT_EN
      if (err && (op == 2'b00 || op == 2'b01) && model_err < 255) model_err++;
`endif
    end
    #1;
    checkOutput();
  endtask

  // Asynchronous reset assertion away from any edge, released at a negedge.
  task automatic doReset();
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    model_flag_reg = 3'b000;
`ifdef ALU_RESULT_BUFFER_ERRCNT_EN
    model_err = 0;
`endif
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_flag_reg", 32'(flag_reg), 32'd0);
    check("rst_out_result", 32'(bus.out_result), 32'd0);
    check("rst_out_flags", 32'(bus.out_flags), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    model_flag_reg = 3'b000;
`ifdef ALU_RESULT_BUFFER_ERRCNT_EN
    model_err = 0;
`endif
    vecs[0] = '{2'b00, 4'h0, 1'b0, 3'b100};
    vecs[1] = '{2'b01, 4'h8, 1'b1, 3'b011};
    vecs[2] = '{2'b11, 4'h3, 1'b0, 3'b011};
    vecs[3] = '{2'b10, 4'h0, 1'b1, 3'b111};
    vecs[4] = '{2'b00, 4'h5, 1'b0, 3'b000};
    vecs[5] = '{2'b10, 4'hF, 1'b0, 3'b000};
    vecs[6] = '{2'b01, 4'hF, 1'b0, 3'b010};
    vecs[7] = '{2'b11, 4'h0, 1'b0, 3'b110};
    vecs[8] = '{2'b00, 4'h7, 1'b1, 3'b001};
    vecs[9] = '{2'b10, 4'h8, 1'b1, 3'b001};

    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 2'b00;
    bus.in_result = 4'h0;
    bus.in_error  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    doReset();

    $display("[TB] table vectors: single push then pop");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].res, vecs[i].err, 1'b0);
      check("vec_out_result", 32'(bus.out_result), 32'(vecs[i].res));
      check("vec_out_flags", 32'(bus.out_flags), 32'(vecs[i].exp_flags));
      applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 1'b1);
      check("vec_flag_reg", 32'(flag_reg), 32'(vecs[i].exp_flags));
    end

    $display("[TB] reset with three entries queued");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 4'(i + 1), 1'b0, 1'b0);
    check("burst_count", 32'(count), 32'd3);
    doReset();
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 1'b1);

    $display("[TB] inheritance uses flag_reg at push time");
    applyStimulus(1'b1, 2'b01, 4'h8, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b11, 4'h3, 1'b0, 1'b0);
    check("inh_count", 32'(count), 32'd2);
    check("inh_first_flags", 32'(bus.out_flags), 32'b011);
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 1'b1);
    check("inh_second_flags", 32'(bus.out_flags), 32'b000);
    check("inh_flag_reg1", 32'(flag_reg), 32'b011);
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 1'b1);
    check("inh_flag_reg2", 32'(flag_reg), 32'b000);

    $display("[TB] fill to full, blocked push, pop reopens");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 2'b00, 4'(i + 9), 1'b0, 1'b0);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_count", 32'(count), 32'd4);
    applyStimulus(1'b1, 2'b00, 4'h2, 1'b0, 1'b0);
    check("full_ignored_count", 32'(count), 32'd4);
    applyStimulus(1'b1, 2'b00, 4'h2, 1'b0, 1'b1);
    check("full_pop_count", 32'(count), 32'd3);
    check("full_reopen", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 1'b1);

    $display("[TB] steady stream");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'b1);
      check("stream_count", 32'(count), 32'd1);
    end
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 1'b1);

`ifdef ALU_RESULT_BUFFER_ERRCNT_EN
    $display("[TB] error counter");
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b10, 4'h1, 1'b1, 1'b1);
    check("errcnt_nand", 32'(err_count), 32'd0);
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 2'b00, 4'h8, 1'b1, 1'b1);
    check("errcnt_sat", 32'(err_count), 32'hFF);
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 1'b1);
    check("errcnt_hold", 32'(err_count), 32'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
